sevenseg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an NDIGITS common-anode 7-seg display.

---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/scan_prescaler.sv | 26 ++
 rtl/sevenseg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
// Code layout: [6] blank, [5] dp, [4] dash, [3:0] hex nibble.
package sevenseg_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic       dash;
        logic [3:0] hex;
    } seg_code_t;

    localparam logic [6:0] BLANK_CODE = 7'b100_0000;

    function automatic logic nib_is_zero(input logic [3:0] nib);
        return nib == 4'h0;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1 and flags the last count.
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;

    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Frame-synchronous seven-segment scan controller with a one-deep pending load.
// Loads commit only at frame boundaries so a frame never mixes old and new digits.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS = 8,
    parameter int DIV     = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   in_value,
    input  logic [NDIGITS-1:0]     in_dp,
    input  logic                   in_dash,
    input  logic                   lzb_en,
    input  logic                   disp_en,
    output logic [6:0]             seg_data,
    output logic [NDIGITS-1:0]     an_n,
    output logic                   frame_tick
);

    localparam int IW = $clog2(NDIGITS);

    logic                 tick;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic                 boundary;
    logic                 accept;
    logic                 commit;

    logic                 pend_vld;
    logic [4*NDIGITS-1:0] pend_value;
    logic [NDIGITS-1:0]   pend_dp;
    logic                 pend_dash;

    logic [4*NDIGITS-1:0] disp_value;
    logic [NDIGITS-1:0]   disp_dp;
    logic                 disp_dash;
    logic [4*NDIGITS-1:0] disp_value_nxt;
    logic [NDIGITS-1:0]   disp_dp_nxt;
    logic                 disp_dash_nxt;

    logic [3:0]           nib;
    logic                 dp_bit;
    logic                 upper_zero;
    logic                 blank;
    seg_code_t            code;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign in_ready = ~pend_vld;
    assign accept   = in_valid & in_ready;
    assign boundary = tick & (idx == IW'(NDIGITS - 1));
    assign commit   = boundary & pend_vld;

    always_comb begin
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    always_comb begin
        disp_value_nxt = disp_value;
        disp_dp_nxt    = disp_dp;
        disp_dash_nxt  = disp_dash;
        if (commit) begin
            disp_value_nxt = pend_value;
            disp_dp_nxt    = pend_dp;
            disp_dash_nxt  = pend_dash;
        end
    end

    // Code is built from post-edge index and display so a new frame starts clean
    always_comb begin
        nib        = 4'h0;
        dp_bit     = 1'b0;
        upper_zero = 1'b1;
        for (int j = 0; j < NDIGITS; j++) begin
            if (IW'(j) == idx_nxt) begin
                nib    = disp_value_nxt[j*4 +: 4];
                dp_bit = disp_dp_nxt[j];
            end
            if (IW'(j) >= idx_nxt && !nib_is_zero(disp_value_nxt[j*4 +: 4])) begin
                upper_zero = 1'b0;
            end
        end
        blank = ~disp_en
              | (lzb_en & (idx_nxt != '0) & upper_zero & ~disp_dash_nxt & ~dp_bit);
        code = '0;
        if (blank) begin
            code.blank = 1'b1;
        end else if (disp_dash_nxt) begin
            code.dash = 1'b1;
        end else begin
            code.hex = nib;
            code.dp  = dp_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            pend_vld   <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_dash  <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_dash  <= 1'b0;
            seg_data   <= BLANK_CODE;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            disp_value <= disp_value_nxt;
            disp_dp    <= disp_dp_nxt;
            disp_dash  <= disp_dash_nxt;
            frame_tick <= boundary;
            if (commit) begin
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend_vld   <= 1'b1;
                pend_value <= in_value;
                pend_dp    <= in_dp;
                pend_dash  <= in_dash;
            end
            if (tick) begin
                seg_data <= code;
                an_n     <= disp_en ? ~(NDIGITS'(1) << idx_nxt) : '1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized bench for sevenseg_scan_ctrl against a frame-arithmetic reference model.
module tb_sevenseg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_value = '0;
    logic [3:0]   in_dp = '0;
    logic         in_dash = 1'b0;
    logic         lzb_en = 1'b0;
    logic         disp_en = 1'b1;
    logic [6:0]   seg_data;
    logic [3:0]   an_n;
    logic         frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    sevenseg_scan_ctrl #(.NDIGITS(N), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_dp      (in_dp),
        .in_dash    (in_dash),
        .lzb_en     (lzb_en),
        .disp_en    (disp_en),
        .seg_data   (seg_data),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge k after reset release, slot T = k/DIV
    int          k;
    logic        m_pvld;
    logic [15:0] m_pval, m_dval;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_pdash, m_ddash;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_ft;

    function automatic logic [6:0] exp_code(input int i);
        logic [15:0] v;
        v = m_dval;
        if (!disp_en) return 7'h40;
        if (lzb_en && i != 0 && (v >> (4 * i)) == 16'h0 && !m_ddash && !m_ddp[i])
            return 7'h40;
        if (m_ddash) return 7'h10;
        return {1'b0, m_ddp[i], 1'b0, v[4*i +: 4]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; m_pvld = 0; m_pval = 0; m_pdp = 0; m_pdash = 0;
            m_dval = 0; m_ddp = 0; m_ddash = 0;
            e_seg = 7'h40; e_an = 4'hF; e_ft = 0;
        end else begin
            logic tk, bnd;
            int t;
            k++;
            tk  = (k % DIV) == 0;
            t   = k / DIV;
            bnd = tk && (t % N) == 0;
            if (bnd && m_pvld) begin
                m_dval = m_pval; m_ddp = m_pdp; m_ddash = m_pdash; m_pvld = 0;
            end else if (in_valid && !m_pvld) begin
                m_pval = in_value; m_pdp = in_dp; m_pdash = in_dash; m_pvld = 1;
            end
            e_ft = bnd;
            if (tk) begin
                e_seg = exp_code(t % N);
                e_an  = disp_en ? ~(4'b0001 << (t % N)) : 4'hF;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("seg_data", 32'(seg_data), 32'(e_seg));
            chk("an_n", 32'(an_n), 32'(e_an));
            chk("frame_tick", 32'(frame_tick), 32'(e_ft));
            chk("in_ready", 32'(in_ready), 32'(!m_pvld));
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic dash);
        int n;
        logic acc;
        n = 0; acc = 0;
        in_valid = 1; in_value = v; in_dp = dp; in_dash = dash;
        while (!acc && n < 200) begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 0;
        if (!acc) chk("load_timeout", 0, 1);
    endtask

    task automatic wait_frame_tick();
        int n;
        n = 0;
        while (!frame_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) chk("ft_timeout", 0, 1);
    endtask

    initial begin
        int ft_cnt;
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;

        repeat (20) @(negedge clk);

        do_load(16'h12A0, 4'b0100, 1'b0);
        repeat (40) @(negedge clk);

        lzb_en = 1;
        do_load(16'h0005, 4'b0000, 1'b0);
        repeat (36) @(negedge clk);
        do_load(16'h0000, 4'b0000, 1'b0);
        repeat (36) @(negedge clk);

        lzb_en = 0;
        do_load(16'hABCD, 4'b0000, 1'b0);
        do_load(16'h1234, 4'b1111, 1'b0);
        repeat (40) @(negedge clk);

        do_load(16'h9999, 4'b0000, 1'b1);
        repeat (36) @(negedge clk);
        disp_en = 0;
        repeat (4) @(negedge clk);
        ft_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_tick) ft_cnt++;
        end
        chk("ft_count_disabled", 32'(ft_cnt), 32'd4);
        disp_en = 1;
        do_load(16'h0F0F, 4'b0010, 1'b0);
        repeat (36) @(negedge clk);

        wait_frame_tick();
        do_load(16'h7777, 4'b1000, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("rst_seg", 32'(seg_data), 32'h40);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            lzb_en  = 1'($urandom_range(0, 1));
            disp_en = ($urandom_range(0, 7) != 0);
            do_load(16'($urandom) >> $urandom_range(0, 12),
                    4'($urandom) & 4'($urandom),
                    $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
